// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch front end.
package fetch_pkg;

    localparam int FETCH_ADDR_W = 8;
    localparam int FETCH_INST_W = 32;

    // Fetch FSM: HALT issues nothing, STREAM issues whenever there is room.
    typedef enum logic [0:0] {
        HALT   = 1'b0,
        STREAM = 1'b1
    } fetch_state_t;

    // One prefetch queue entry at the default widths.
    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of {pc, inst} entries. Flush wins over push;
// a pop together with a flush leaves the buffer empty. DEPTH must be a
// power of two so the pointers wrap by natural overflow.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  entry_t                       push_data_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output entry_t                       head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop_s;
    logic             do_push_s;

    // A pop frees a slot in the same cycle, so push into a full buffer is fine then.
    always_comb begin
        do_pop_s  = pop_i & (count_q != {CNT_W{1'b0}});
        do_push_s = push_i & ((count_q != CNT_W'(DEPTH)) | do_pop_s);
    end

    // Next pointer / occupancy; a flush clears everything regardless of push/pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = {PTR_W{1'b0}};
            wr_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CNT_W'(1'b1);
                2'b01:   count_d = count_q - CNT_W'(1'b1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; cleared on reset so the head reads as zero when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push_s && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues single-cycle
// instruction-memory reads, and queues returned words for decode.
// Redirects flush the queue and drop any read still in flight.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int INST_W = FETCH_INST_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic              squash_q, squash_d;

    logic              pop_s;
    logic              push_s;
    logic              issue_s;
    logic [CNT_W-1:0]  count_s;
    logic [CNT_W:0]    pending_s;
    entry_t            push_entry_s;
    entry_t            head_s;

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push_s),
        .push_data_i (push_entry_s),
        .pop_i       (pop_s),
        .flush_i     (redirect_valid),
        .head_o      (head_s),
        .count_o     (count_s)
    );

    // Handshake, response capture and issue decision. The slot count includes
    // the read in flight, and a pop this cycle frees a slot for a new read.
    always_comb begin
        pop_s             = (count_s != {CNT_W{1'b0}}) & inst_ready;
        push_s            = inflight_q & ~squash_q;
        push_entry_s.pc   = inflight_pc_q;
        push_entry_s.inst = imem_rdata;
        pending_s         = {1'b0, count_s}
                          + (CNT_W+1)'(inflight_q)
                          - (CNT_W+1)'(pop_s);
        issue_s           = (state_q == STREAM) & fetch_en & ~redirect_valid
                          & (pending_s < (CNT_W+1)'(DEPTH));
    end

    // FSM next state: fetch_en alone moves between HALT and STREAM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HALT: begin
                if (fetch_en) begin
                    state_d = STREAM;
                end else begin
                    state_d = HALT;
                end
            end
            STREAM: begin
                if (!fetch_en) begin
                    state_d = HALT;
                end else begin
                    state_d = STREAM;
                end
            end
            default: state_d = HALT;
        endcase
    end

    // Fetch PC, in-flight and squash tracking.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        squash_d      = squash_q;

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
        end else if (issue_s) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(1'b1);
        end else begin
            fetch_pc_d = fetch_pc_q;
        end

        // A response always returns the cycle after its request, so any
        // outstanding read retires this cycle unless a new one replaces it.
        if (issue_s) begin
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
        end else if (inflight_q) begin
            inflight_d    = 1'b0;
        end else begin
            inflight_d    = inflight_q;
        end

        // A read that outlives a redirect must be dropped when it returns;
        // one returning during the redirect is discarded by the flush itself.
        if (redirect_valid && inflight_d) begin
            squash_d = 1'b1;
        end else if (inflight_q) begin
            squash_d = 1'b0;
        end else begin
            squash_d = squash_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HALT;
            fetch_pc_q    <= {ADDR_W{1'b0}};
            inflight_pc_q <= {ADDR_W{1'b0}};
            inflight_q    <= 1'b0;
            squash_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            squash_q      <= squash_d;
        end
    end

    assign imem_req   = issue_s;
    assign imem_addr  = fetch_pc_q;
    assign inst_valid = (count_s != {CNT_W{1'b0}});
    assign inst_data  = head_s.inst;
    assign inst_pc    = head_s.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a reference stream of expected PCs is
// kept in a queue (restarted on reset/redirect), and a monitor pops and
// compares every instruction that decode accepts.
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [7:0]  inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;

    int n_cmp = 0;
    int n_mis = 0;
    int exp_q[$];
    int exp_next = 0;
    int pops = 0;

    fetch_unit #(.ADDR_W(8), .INST_W(32), .DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input int a);
        return 32'(a) * 32'h01010101;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected instruction stream: consecutive PCs modulo 256 from a start point.
    task automatic topup();
        while (exp_q.size() < 8) begin
            exp_q.push_back(exp_next);
            exp_next = (exp_next + 1) % 256;
        end
    endtask

    task automatic restart(input int pc);
        exp_q.delete();
        exp_next = pc;
        topup();
    endtask

    // Instruction memory: word for address a is a*0x01010101, one cycle later.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= word_of(int'(imem_addr));
        else          imem_rdata <= $urandom;
    end

    // Monitor: compare every accepted instruction, then apply any redirect.
    always @(negedge clk) begin
        int e;
        if (rst_n) begin
            if (inst_valid && inst_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL sb_empty: actual pc=%0h required=none", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc", inst_pc, e);
                    check("sb_data", inst_data, word_of(e));
                    topup();
                end
            end
            if (redirect_valid) restart(int'(redirect_pc));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        step();
        step();
        restart(0);
        rst_n = 1'b1;
    endtask

    int found, reqs, gaps, pb, n, halt_pc, last_pc;
    int got[3];

    initial begin
        rst_n = 1'b0; fetch_en = 1'b1; inst_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 8'h00;
        restart(0);
        repeat (3) step();
        @(negedge clk);
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_valid", inst_valid, 0);
        check("rst_data", inst_data, 0);
        check("rst_pc", inst_pc, 0);

        // Release: HALT this cycle, first request next cycle, valid two after it.
        step(); rst_n = 1'b1;
        @(negedge clk); check("rel_no_req", imem_req, 0);
        step(); @(negedge clk);
        check("first_req", imem_req, 1);
        check("first_addr", imem_addr, 0);
        step(); @(negedge clk); check("first_valid_early", inst_valid, 0);
        step(); @(negedge clk);
        check("first_valid", inst_valid, 1);
        check("first_pc", inst_pc, 0);

        // Streaming: one instruction per cycle.
        gaps = 0;
        repeat (20) begin step(); @(negedge clk); if (!inst_valid) gaps++; end
        check("stream_gaps", gaps, 0);

        // Backpressure: no requests while the queue is full, nothing lost.
        step(); inst_ready = 1'b0; reqs = 0;
        repeat (10) begin @(negedge clk); if (imem_req) reqs++; step(); end
        check("bp_no_req", reqs, 0);
        check("bp_valid", inst_valid, 1);
        check("bp_head", inst_pc, exp_q[0]);
        inst_ready = 1'b1; gaps = 0;
        repeat (5) begin @(negedge clk); if (!inst_valid) gaps++; step(); end
        check("bp_release_gaps", gaps, 0);

        // Redirect one cycle after the request for PC 3.
        do_reset(); found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk); if (imem_req && imem_addr == 8'd3) found = 1;
            step();
        end
        check("find_req3", found, 1);
        redirect_valid = 1'b1; redirect_pc = 8'h40;
        step(); redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_valid_drop", inst_valid, 0);
        check("redir_req", imem_req, 1);
        check("redir_addr", imem_addr, 8'h40);
        step(); @(negedge clk); check("redir_valid_r2", inst_valid, 0);
        step(); @(negedge clk);
        check("redir_valid_r3", inst_valid, 1);
        check("redir_pc", inst_pc, 8'h40);
        check("redir_data", inst_data, 32'h40404040);

        // Redirect together with a pop of the head at PC 5.
        do_reset(); found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            step(); if (inst_valid && inst_pc == 8'd5) found = 1;
        end
        check("find_head5", found, 1);
        redirect_valid = 1'b1; redirect_pc = 8'h10; pb = pops;
        step(); redirect_valid = 1'b0;
        check("pop_with_redir", pops - pb, 1);
        last_pc = -1;
        for (int i = 0; i < 10 && last_pc < 0; i++) begin
            @(negedge clk); if (inst_valid) last_pc = int'(inst_pc);
            step();
        end
        check("after_redir_pc", last_pc, 8'h10);

        // Wrap: 0xFE, 0xFF, 0x00.
        redirect_valid = 1'b1; redirect_pc = 8'hFE;
        step(); redirect_valid = 1'b0; n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (inst_valid && inst_ready && n < 3) begin got[n] = int'(inst_pc); n++; end
            step();
        end
        check("wrap_count", n, 3);
        check("wrap_pc0", got[0], 8'hFE);
        check("wrap_pc1", got[1], 8'hFF);
        check("wrap_pc2", got[2], 8'h00);

        // Halt with a read in flight: the word still arrives, then silence.
        inst_ready = 1'b0; repeat (4) step();
        inst_ready = 1'b1; found = 0; halt_pc = -1;
        for (int i = 0; i < 10 && found == 0; i++) begin
            @(negedge clk);
            if (imem_req) begin found = 1; halt_pc = int'(imem_addr); end
            step();
        end
        check("halt_find_req", found, 1);
        fetch_en = 1'b0; inst_ready = 1'b0; reqs = 0;
        repeat (10) begin @(negedge clk); if (imem_req) reqs++; step(); end
        check("halt_no_req", reqs, 0);
        inst_ready = 1'b1; last_pc = -1;
        repeat (6) begin
            @(negedge clk); if (inst_valid) last_pc = int'(inst_pc);
            if (imem_req) reqs++;
            step();
        end
        check("halt_last_pc", last_pc, halt_pc);
        check("halt_no_req_drain", reqs, 0);
        @(negedge clk); check("halt_empty", inst_valid, 0);

        // Asynchronous reset in the middle of a cycle.
        fetch_en = 1'b1;
        repeat (6) step();
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", inst_valid, 0);
        check("async_req", imem_req, 0);
        check("async_pc", inst_pc, 0);
        check("async_data", inst_data, 0);
        do_reset();

        // Randomized traffic against the reference stream.
        pb = pops;
        for (int i = 0; i < 3000; i++) begin
            step();
            fetch_en   = ($urandom_range(0, 9) != 0);
            inst_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = 8'($urandom);
            end else begin
                redirect_valid = 1'b0;
            end
        end
        check("rand_progress", (pops - pb) > 500, 1);
        step();
        fetch_en = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0;
        gaps = 0;
        repeat (4) step();
        repeat (10) begin @(negedge clk); if (!inst_valid) gaps++; step(); end
        check("final_stream_gaps", gaps, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the multicycle CPU. It owns the fetch PC, issues reads to instruction memory, and buffers returned words with their PCs in a small prefetch queue. It presents them to the decode stage over a valid/ready handshake. Branch redirects from execute flush the queue and squash any in-flight read.

## Interface
Parameters:
- ADDR_W, 8: PC / instruction-memory address width.
- INST_W, 32: instruction width.
- DEPTH, 2: prefetch queue entries. Must be a power of two, ≥2.

Ports:
- clk, in, 1: single clock; all state updates on rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- fetch_en, in, 1: 1 = fetching allowed; 0 = halt new requests.
- imem_req, out, 1: read strobe to instruction memory.
- imem_addr, out, ADDR_W: read address. Valid when imem_req=1.
- imem_rdata, in, INST_W: read data. Valid exactly 1 cycle after the imem_req cycle.
- inst_valid, out, 1: queue head holds a valid instruction.
- inst_data, out, INST_W: head instruction.
- inst_pc, out, ADDR_W: PC of the head instruction.
- inst_ready, in, 1: decode accepts the head this cycle.
- redirect_valid, in, 1: branch taken; flush and refetch.
- redirect_pc, in, ADDR_W: new fetch PC.

## Operation
- States: HALT, STREAM. Reset state is HALT.
  - HALT→STREAM when fetch_en=1.
  - STREAM→HALT when fetch_en=0.
  - Redirect does not change state.
- Registers:
  - fetch_pc
  - inflight (1 bit)
  - inflight_pc
  - squash (1 bit)
  - queue of {pc, inst}
  - occupancy count, 0..DEPTH
- Pop: pop = inst_valid & inst_ready. The head is removed at the clock edge.
- Issue condition: state==STREAM & fetch_en & !redirect_valid & (occupancy + inflight − pop < DEPTH).
- On issue:
  - imem_req=1 and imem_addr=fetch_pc, both combinational from registers.
  - inflight<=1 and inflight_pc<=fetch_pc.
  - fetch_pc<=fetch_pc+1, modulo 2^ADDR_W, so 0xFF wraps to 0x00.
- Response: in the cycle after an issue, when inflight=1 and squash=0, push {inflight_pc, imem_rdata}. If squash=1, drop the data. In both cases clear inflight and squash unless a new issue occurs in the same cycle.
- Push and pop in the same cycle:
  - Occupancy is unchanged.
  - With occupancy 0, the push still lands and inst_valid asserts the next cycle. There is no bypass.
- Redirect (redirect_valid=1):
  - Any pop in the same cycle is honoured: decode consumed the head.
  - Queue is emptied and occupancy<=0.
  - If inflight=1, its response is dropped: squash<=1, or the response is discarded directly if it returns this cycle.
  - fetch_pc<=redirect_pc. No issue occurs this cycle.
  - The first issue at redirect_pc is the next cycle, if STREAM and fetch_en.
- Halt: fetch_en=0 stops new issues only. An in-flight response is still captured, and the queue still drains to decode.
- Outputs are driven from registers only: inst_valid = (occupancy≠0), and inst_data/inst_pc come from the head entry.

## Timing
- Reset values:
  - imem_req=0, imem_addr=0.
  - inst_valid=0, inst_data=0, inst_pc=0.
  - fetch_pc=0, occupancy=0, inflight=0, squash=0.
  - State=HALT.
- Reset asserted mid-operation: all of the above are cleared immediately, asynchronously. A pending imem response after reset release is ignored, because inflight=0.
- Timeline for a request issued in cycle N: data is returned in cycle N+1, and inst_valid=1 with that word from cycle N+2.
- Throughput: with DEPTH=2 and inst_ready held at 1, one instruction per cycle is sustained.
- Redirect in cycle R: inst_valid=0 in R+1. The first request at redirect_pc is in R+1, and its inst_valid is in R+3.
- Backpressure: with inst_ready=0, at most DEPTH entries are queued. No further imem_req is issued, and no data is lost.

## Structure
- Package fetch_pkg:
  - ADDR_W and INST_W defaults.
  - Enum fetch_state_t {HALT, STREAM}.
  - Struct fetch_entry_t {pc, inst}.
- Sub-module fetch_fifo:
  - DEPTH-entry circular buffer of fetch_entry_t, with push, pop, flush, head output and count.
  - Flush has priority over push.
  - A simultaneous pop and flush leaves the buffer empty.
- fetch_unit holds the FSM, the PC, the in-flight/squash tracking and the issue logic.

## Test plan
- Reset: hold rst_n=0 with fetch_en=1 → no imem_req and all outputs 0. Release rst_n → first imem_req with addr 0x00 in the next cycle, and inst_valid with inst_pc=0x00 two cycles after that request.
- Streaming: imem returns addr×0x01010101, inst_ready=1 → inst_pc runs 0,1,2,… one per cycle, and each inst_data matches its address.
- Backpressure: inst_ready=0 for 10 cycles → queue holds PCs 0 and 1, no third request is issued, and imem_req stays 0. Release → PCs 0,1,2 are delivered in order with no gaps or duplicates.
- Redirect with read in flight: issue a redirect to 0x40 the cycle after the request for PC 3 → the word for PC 3 is never presented. inst_valid drops, and the next delivered inst_pc is 0x40 with the correct data.
- Redirect plus pop in the same cycle: head PC 5 accepted while redirect_pc=0x10 → PC 5 is consumed exactly once, and the next delivered PC is 0x10.
- Wrap and halt:
  - Redirect to 0xFE → delivered PCs are 0xFE, 0xFF, 0x00.
  - Drop fetch_en while a read is in flight → that word is still delivered, then no further imem_req is issued.
